// File: rtl/wb_arbiter_pkg.sv
// Shared writeback packet types for the execute-to-commit path.
// Holds the completion packet layout and small index helpers.
package wb_arbiter_pkg;

  localparam int WB_ITAG_W  = 8;
  localparam int WB_DATA_W  = 64;
  localparam int WB_CAUSE_W = 5;

  typedef struct packed {
    logic [WB_ITAG_W-1:0]  itag;
    logic [WB_DATA_W-1:0]  rdata;
    logic                  rd_wen;
    logic                  excp;
    logic [WB_CAUSE_W-1:0] cause;
  } wb_pkt_t;

  function automatic int wb_wrap_inc(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/wb_rr_grant.sv
// Request vector to one-hot grant plus index; round-robin when
// WB_ARB_ROUND_ROBIN_EN is defined, otherwise lowest index wins.
module wb_rr_grant
  import wb_arbiter_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int IDX_W = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req_i,
`ifdef WB_ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic [NPORT-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

`ifdef WB_ARB_ROUND_ROBIN_EN
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    // search starts at the pointer and wraps
    for (int k = 0; k < NPORT; k++) begin
      j = (int'(ptr_i) + k) % NPORT;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end
`else
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NPORT execute units into one registered commit slot.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int NPORT  = 4,
  parameter  int ITAG_W = 8,
  localparam int IDX_W  = $clog2(NPORT)
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  flush_i,
  input  logic [NPORT-1:0]      wb_valid_i,
  output logic [NPORT-1:0]      wb_ready_o,
  input  wb_pkt_t [NPORT-1:0]   wb_pkt_i,
  output logic                  cmt_valid_o,
  input  logic                  cmt_ready_i,
  output wb_pkt_t               cmt_pkt_o,
  output logic [IDX_W-1:0]      cmt_src_o
);

  if (ITAG_W != WB_ITAG_W) begin : g_itag_chk
    $error("ITAG_W must match the shared packet tag width");
  end

  logic             slot_free;
  logic             grant_en;
  logic             req_any;
  logic [NPORT-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;

  logic             cmt_valid_q, cmt_valid_d;
  wb_pkt_t          cmt_pkt_q, cmt_pkt_d;
  logic [IDX_W-1:0] cmt_src_q, cmt_src_d;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  wb_rr_grant #(
    .NPORT (NPORT),
    .IDX_W (IDX_W)
  ) u_grant (
    .req_i (wb_valid_i),
`ifdef WB_ARB_ROUND_ROBIN_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (req_any)
  );

  // ROB pop frees the slot in the same cycle, so ready sees cmt_ready_i
  assign slot_free  = !cmt_valid_q || cmt_ready_i;
  assign grant_en   = slot_free && !flush_i && !arst_i && req_any;
  assign wb_ready_o = grant_en ? gnt : '0;

  always_comb begin
    cmt_valid_d = cmt_valid_q;
    cmt_pkt_d   = cmt_pkt_q;
    cmt_src_d   = cmt_src_q;
    if (flush_i) begin
      cmt_valid_d = 1'b0;
    end else if (slot_free) begin
      cmt_valid_d = grant_en;
      if (grant_en) begin
        cmt_pkt_d = wb_pkt_i[gnt_idx];
        cmt_src_d = gnt_idx;
      end
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) begin
      ptr_d = IDX_W'(wb_wrap_inc(int'(gnt_idx), NPORT));
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cmt_valid_q <= 1'b0;
      cmt_pkt_q   <= '0;
      cmt_src_q   <= '0;
    end else begin
      cmt_valid_q <= cmt_valid_d;
      cmt_pkt_q   <= cmt_pkt_d;
      cmt_src_q   <= cmt_src_d;
    end
  end

  assign cmt_valid_o = cmt_valid_q;
  assign cmt_pkt_o   = cmt_pkt_q;
  assign cmt_src_o   = cmt_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and scoreboarded bench for wb_arbiter (4 ports).
// Arbitration expectations follow WB_ARB_ROUND_ROBIN_EN.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             arst;
  logic             flush;
  logic [3:0]       wb_valid;
  logic [3:0]       wb_ready;
  wb_pkt_t [3:0]    wb_pkt;
  logic             cmt_valid;
  logic             cmt_ready;
  wb_pkt_t          cmt_pkt;
  logic [1:0]       cmt_src;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.NPORT(4), .ITAG_W(8)) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .flush_i     (flush),
    .wb_valid_i  (wb_valid),
    .wb_ready_o  (wb_ready),
    .wb_pkt_i    (wb_pkt),
    .cmt_valid_o (cmt_valid),
    .cmt_ready_i (cmt_ready),
    .cmt_pkt_o   (cmt_pkt),
    .cmt_src_o   (cmt_src)
  );

  function automatic wb_pkt_t mk(input logic [7:0] t, input logic [63:0] d);
    wb_pkt_t p;
    p = '0;
    p.itag = t;
    p.rdata = d;
    p.rd_wen = 1'b1;
    return p;
  endfunction

  task automatic test_reset();
    arst = 1'b1; flush = 1'b0; cmt_ready = 1'b1; wb_valid = 4'hF;
    for (int i = 0; i < 4; i++) wb_pkt[i] = mk(8'hAA, 64'h1234);
    @(posedge clk); #1;
    checks++; if (cmt_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %b want 0", cmt_valid); end
    checks++; if (cmt_src !== 2'd0) begin errors++;
      $display("FAIL rst_src got %0d want 0", cmt_src); end
    checks++; if (cmt_pkt !== '0) begin errors++;
      $display("FAIL rst_pkt got %h want 0", cmt_pkt); end
    checks++; if (wb_ready !== 4'b0) begin errors++;
      $display("FAIL rst_ready got %b want 0000", wb_ready); end
    @(negedge clk); arst = 1'b0; wb_valid = 4'h0;
  endtask

  task automatic test_single();
    @(negedge clk);
    cmt_ready = 1'b1; wb_valid = 4'b0010; wb_pkt[1] = mk(8'h12, 64'hDEAD);
    #1;
    checks++; if (wb_ready !== 4'b0010) begin errors++;
      $display("FAIL single_ready got %b want 0010", wb_ready); end
    @(posedge clk); #1;
    checks++; if (cmt_valid !== 1'b1) begin errors++;
      $display("FAIL single_valid got %b want 1", cmt_valid); end
    checks++; if (cmt_pkt.itag !== 8'h12) begin errors++;
      $display("FAIL single_itag got %h want 12", cmt_pkt.itag); end
    checks++; if (cmt_pkt.rdata !== 64'hDEAD) begin errors++;
      $display("FAIL single_rdata got %h want dead", cmt_pkt.rdata); end
    checks++; if (cmt_src !== 2'd1) begin errors++;
      $display("FAIL single_src got %0d want 1", cmt_src); end
    @(negedge clk); wb_valid = 4'b0; #1;
    checks++; if (wb_ready !== 4'b0) begin errors++;
      $display("FAIL idle_ready got %b want 0000", wb_ready); end
    @(posedge clk); #1;
    checks++; if (cmt_valid !== 1'b0) begin errors++;
      $display("FAIL drain_valid got %b want 0", cmt_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    wb_valid = 4'b0100; wb_pkt[2] = mk(8'h22, 64'h2222); cmt_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmt_pkt.itag !== 8'h22 || cmt_valid !== 1'b1) begin errors++;
      $display("FAIL bp_load got %h/%b want 22/1", cmt_pkt.itag, cmt_valid); end
    @(negedge clk);
    wb_valid = 4'b0101; wb_pkt[0] = mk(8'h20, 64'h2020); cmt_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (wb_ready !== 4'b0) begin errors++;
        $display("FAIL bp_ready[%0d] got %b want 0000", c, wb_ready); end
      @(posedge clk); #1;
      checks++;
      if (cmt_pkt.itag !== 8'h22 || cmt_src !== 2'd2 || cmt_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d] got %h/%0d/%b want 22/2/1",
                 c, cmt_pkt.itag, cmt_src, cmt_valid);
      end
      @(negedge clk);
    end
    cmt_ready = 1'b1; #1;
    checks++; if (wb_ready !== 4'b0001) begin errors++;
      $display("FAIL bp_release got %b want 0001", wb_ready); end
    @(posedge clk); #1;
    checks++; if (cmt_src !== 2'd0 || cmt_pkt.itag !== 8'h20) begin errors++;
      $display("FAIL bp_next got %0d/%h want 0/20", cmt_src, cmt_pkt.itag); end
    @(negedge clk); wb_valid = 4'b0;
  endtask

  task automatic test_arbitration();
    int e;
    @(negedge clk); arst = 1'b1; #2; arst = 1'b0;
    for (int i = 0; i < 4; i++) wb_pkt[i] = mk(8'(8'h30 + i), 64'(i));
    wb_valid = 4'hF; cmt_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      e = RR ? c % 4 : 0;
      #1;
      checks++; if (wb_ready !== 4'(1 << e)) begin errors++;
        $display("FAIL arb_ready[%0d] got %b want %b", c, wb_ready, 4'(1 << e)); end
      @(posedge clk); #1;
      checks++; if (cmt_src !== 2'(e) || cmt_pkt.itag !== 8'(8'h30 + e)) begin
        errors++;
        $display("FAIL arb_out[%0d] got %0d/%h want %0d/%h",
                 c, cmt_src, cmt_pkt.itag, e, 8'(8'h30 + e));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    int e;
    wb_valid = 4'b1000; flush = 1'b1; cmt_ready = 1'b1; #1;
    checks++; if (wb_ready !== 4'b0) begin errors++;
      $display("FAIL flush_ready got %b want 0000", wb_ready); end
    @(posedge clk); #1;
    checks++; if (cmt_valid !== 1'b0) begin errors++;
      $display("FAIL flush_valid got %b want 0", cmt_valid); end
    checks++; if (cmt_pkt.itag !== 8'h30) begin errors++;
      $display("FAIL flush_keep got %h want 30", cmt_pkt.itag); end
    @(negedge clk); flush = 1'b0; wb_valid = 4'hF;
    e = RR ? 1 : 0;
    #1;
    checks++; if (wb_ready !== 4'(1 << e)) begin errors++;
      $display("FAIL flush_ptr got %b want %b", wb_ready, 4'(1 << e)); end
    @(posedge clk); #1;
    checks++; if (cmt_src !== 2'(e) || cmt_valid !== 1'b1) begin errors++;
      $display("FAIL flush_next got %0d/%b want %0d/1", cmt_src, cmt_valid, e); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); #2; arst = 1'b1; #1;
    checks++; if (cmt_valid !== 1'b0 || cmt_src !== 2'd0) begin errors++;
      $display("FAIL amid_out got %b/%0d want 0/0", cmt_valid, cmt_src); end
    checks++; if (wb_ready !== 4'b0 || cmt_pkt !== '0) begin errors++;
      $display("FAIL amid_clr got %b/%h want 0000/0", wb_ready, cmt_pkt); end
    #1; arst = 1'b0; #1;
    checks++; if (wb_ready !== 4'b0001) begin errors++;
      $display("FAIL amid_grant got %b want 0001", wb_ready); end
    @(posedge clk); #1;
    checks++; if (cmt_src !== 2'd0 || cmt_valid !== 1'b1) begin errors++;
      $display("FAIL amid_next got %0d/%b want 0/1", cmt_src, cmt_valid); end
    @(negedge clk); wb_valid = 4'b0;
  endtask

  task automatic test_throughput();
    logic [63:0] rd [4][25];
    int sent [4];
    int got [4];
    bit hold [4];
    int total = 0;
    int cyc = 0;
    int s;
    for (int p = 0; p < 4; p++) begin
      sent[p] = 0; got[p] = 0; hold[p] = 1'b0;
      for (int k = 0; k < 25; k++) rd[p][k] = {$urandom, $urandom};
    end
    @(negedge clk); wb_valid = 4'b0; cmt_ready = 1'b1;
    @(negedge clk);
    while (total < 100 && cyc < 3000) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        if (!hold[p]) begin
          wb_valid[p] = (sent[p] < 25) && ($urandom_range(0, 9) < 6);
          if (sent[p] < 25) wb_pkt[p] = mk(8'(p * 64 + sent[p]), rd[p][sent[p]]);
        end
      end
      cmt_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (cmt_valid && cmt_ready) begin
        s = int'(cmt_src);
        checks++;
        if (got[s] >= 25) begin
          errors++;
          $display("FAIL tp_extra port %0d got itag %h want none", s, cmt_pkt.itag);
        end else if (cmt_pkt.itag !== 8'(s * 64 + got[s]) ||
                     cmt_pkt.rdata !== rd[s][got[s]]) begin
          errors++;
          $display("FAIL tp_pkt port %0d got %h/%h want %h/%h", s, cmt_pkt.itag,
                   cmt_pkt.rdata, 8'(s * 64 + got[s]), rd[s][got[s]]);
        end
        got[s]++;
        total++;
      end
      for (int p = 0; p < 4; p++) begin
        if (wb_valid[p] && wb_ready[p]) begin
          sent[p]++;
          hold[p] = 1'b0;
        end else begin
          hold[p] = wb_valid[p];
        end
      end
      cyc++;
    end
    wb_valid = 4'b0;
    checks++; if (total != 100) begin errors++;
      $display("FAIL tp_count got %0d want 100", total); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_arbitration();
    test_flush();
    test_reset_mid();
    test_throughput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback-side receiver for the execute-stage writeback protocol. It accepts completion packets from up to NPORT execute-unit masters (bypass, ALU, MDU, LSU, ...), picks one per cycle, and registers it into a single completion slot toward the ROB/commit stage. It is the slave end of the valid/ready writeback handshake that execute units drive.

## Interface
- NPORT, 4: number of writeback slave ports (2..8).
- ITAG_W, 8: instruction tag width.
- clk_i  in  1  clock
- arst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  pipeline flush (from pip_flush_interface)
- wb_valid_i  in  NPORT  per-port packet valid
- wb_ready_o  out  NPORT  per-port accept; transfer when valid&ready
- wb_pkt_i  in  NPORT x wb_pkt_t  per-port packet {itag[7:0], rdata[63:0], rd_wen, excp, cause[4:0]} = 79 bits
- cmt_valid_o  out  1  completion slot valid
- cmt_ready_i  in  1  ROB accepts completion
- cmt_pkt_o  out  wb_pkt_t  registered completion packet
- cmt_src_o  out  $clog2(NPORT)  index of port that supplied cmt_pkt_o

## Operation
- Output slot "free" = !cmt_valid_o | cmt_ready_i.
- Grant: among asserted wb_valid_i, select one port (policy per Configuration). wb_ready_o[g]=1 only for the granted port, only when slot free and flush_i=0; all other bits 0.
- No combinational path from wb_valid_i[i] to wb_ready_o[i] of the same port except through the grant; wb_ready_o depends on cmt_ready_i (documented comb path).
- On transfer: cmt_pkt_o <= wb_pkt_i[g], cmt_src_o <= g, cmt_valid_o <= 1.
- Slot free, no request: cmt_valid_o <= 0.
- cmt_valid_o=1 & cmt_ready_i=0: cmt_pkt_o, cmt_src_o held stable; no port granted.
- Flush: cmt_valid_o <= 0 next cycle; no transfer on flush cycle; packet data not cleared; arbitration pointer not changed.
- Sources must hold packet stable while valid&!ready; block does not buffer rejected packets.

## Timing
- Reset values: cmt_valid_o=0, cmt_src_o=0, rr pointer=0; cmt_pkt_o reset to 0 (itag=0, rdata=0, flags=0).
- Latency: transfer at edge N -> cmt_valid_o visible after edge N; one completion per cycle sustained when cmt_ready_i held 1.
- Simultaneous: ROB pops and new port granted in same cycle -> back-to-back, no bubble.
- Flush and cmt_ready_i same cycle: flush wins, slot empties.
- Reset asserted mid-transfer: all outputs to reset values asynchronously; wb_ready_o=0 while arst_i=1.

## Configuration
- WB_ARB_ROUND_ROBIN_EN defined: round-robin. Pointer p (init 0); search ports p, p+1, ... mod NPORT; first valid wins; after a transfer from port g, p <= (g+1) mod NPORT. Pointer only updates on actual transfer.
- Not defined: fixed priority, lowest index wins; pointer logic absent; cmt behaviour otherwise identical.

## Structure
- wb_pkt_t packed struct, WB_CAUSE_W=5, itag width constant in prv664 shared package (prv664_define.svh domain).
- One sub-module: wb_rr_grant (NPORT request vector + pointer -> one-hot grant + index); in fixed-priority build it reduces to priority encoder.
- Output register in wb_arbiter top.

## Test plan
- Single port: port1 valid, itag=0x12, rdata=0xDEAD, ROB ready -> wb_ready_o=4'b0010 one cycle, next cycle cmt_valid_o=1, itag 0x12, cmt_src_o=1.
- Backpressure: slot full, cmt_ready_i=0 for 3 cycles, port0/2 valid -> wb_ready_o=0, cmt_pkt_o unchanged; on cmt_ready_i=1 port0 granted same cycle.
- Round-robin (macro on): all 4 ports valid continuously, ROB ready -> grant order 0,1,2,3,0; fixed (macro off) -> always 0.
- Flush: cmt_valid_o=1, flush_i=1 with cmt_ready_i=1 and port3 valid -> wb_ready_o=0, next cycle cmt_valid_o=0, pointer unchanged.
- Reset mid-stream: arst_i pulse while cmt_valid_o=1 -> cmt_valid_o=0 immediately, cmt_src_o=0, next grant from port 0.
- Throughput: 100 random packets over 4 ports, ROB ready 70% -> every packet appears exactly once, per-port order preserved.
